// File: rtl/register_bank_pkg.sv
// register_bank_pkg: shared FSM state encoding and request mode constants for register_bank_reader.
package register_bank_pkg;
  typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;
  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_DUMP = 1'b1;
endpackage

// File: rtl/reg_word_mux.sv
// reg_word_mux: combinational NUM_REGS:1 selector of one WIDTH-bit word from the flattened register bus.
module reg_word_mux #(
  parameter int NUM_REGS = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*WIDTH-1:0] RegIn,
  input  logic [AW-1:0]             Idx,
  output logic [WIDTH-1:0]          Word
);
  assign Word = RegIn[Idx*WIDTH +: WIDTH];
endmodule

// File: rtl/register_bank_reader.sv
// register_bank_reader: streams one register or the whole bank out over a valid/ready port.
// Optional READ_PARITY_EN adds OutParity, the XOR of OutData, registered alongside it.
module register_bank_reader
  import register_bank_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REGS*WIDTH-1:0] RegIn,
  input  logic                      Start,
  input  logic                      Mode,
  input  logic [AW-1:0]             Addr,
  output logic [WIDTH-1:0]          OutData,
  output logic [AW-1:0]             OutAddr,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic                      Busy,
`ifdef READ_PARITY_EN
  output logic                      OutParity,
`endif
  output logic                      Done
);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
  state_t            r_state;
  logic              r_mode;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [AW-1:0]     r_out_addr;
  logic [AW-1:0]     w_idx;
  logic [WIDTH-1:0]  w_word;
  logic              w_xfer;
  logic              w_last;
  logic              w_load;
  // In IDLE the mux looks at the first index of a new request, otherwise at the next one in a dump.
  assign w_idx  = (r_state == IDLE) ? ((Mode == MODE_DUMP) ? '0 : Addr) : r_out_addr + AW'(1);
  assign w_xfer = r_out_valid && OutReady;
  assign w_last = (r_mode == MODE_SINGLE) || (r_out_addr == LAST);
  assign w_load = ((r_state == IDLE) && Start) || ((r_state == SEND) && w_xfer && !w_last);
  reg_word_mux #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) u_mux (
    .RegIn(RegIn),
    .Idx  (w_idx),
    .Word (w_word)
  );
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_mode      <= MODE_SINGLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (Start) begin
          r_mode      <= Mode;
          r_out_valid <= 1'b1;
          r_state     <= SEND;
        end
        SEND: if (w_xfer && w_last) begin
          r_out_valid <= 1'b0;
          r_state     <= FINISH;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Words are sampled from RegIn at load time, so a stalled word never changes under the consumer.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_out_data <= '0;
      r_out_addr <= '0;
    end else if (w_load) begin
      r_out_data <= w_word;
      r_out_addr <= w_idx;
    end
  end
`ifdef READ_PARITY_EN
  logic r_out_parity;
  always_ff @(posedge Clk) begin
    if (!Reset) r_out_parity <= 1'b0;
    else if (w_load) r_out_parity <= ^w_word;
  end
  assign OutParity = r_out_parity;
`endif
  assign OutData  = r_out_data;
  assign OutAddr  = r_out_addr;
  assign OutValid = r_out_valid;
  assign Busy     = (r_state != IDLE);
  assign Done     = (r_state == FINISH);
endmodule

// File: tb/tb_register_bank_reader.sv
// tb_register_bank_reader: directed and randomized checks of register_bank_reader against a transfer-list model.
module tb_register_bank_reader;
  logic         Clk, Reset, Start, Mode, OutReady;
  logic [3:0]   Addr, OutAddr;
  logic [511:0] RegIn;
  logic [31:0]  OutData;
  logic         OutValid, Busy, Done;
`ifdef READ_PARITY_EN
  logic         OutParity;
`endif
  bit   [31:0]  regs [16];
  int           errors = 0;
  int           checks = 0;

  register_bank_reader #(.NUM_REGS(16), .WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .RegIn(RegIn), .Start(Start), .Mode(Mode), .Addr(Addr),
    .OutData(OutData), .OutAddr(OutAddr), .OutValid(OutValid), .OutReady(OutReady),
    .Busy(Busy),
`ifdef READ_PARITY_EN
    .OutParity(OutParity),
`endif
    .Done(Done)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_regs;
    for (int i = 0; i < 16; i++) RegIn[i*32 +: 32] = regs[i];
  endtask

  task automatic preload;
    for (int i = 0; i < 16; i++) regs[i] = 32'(i + 1);
    apply_regs();
  endtask

  // rdy_kind: 0 = always ready, 1 = toggle starting stalled, 2 = random; poke issues a stray Start mid-request
  task automatic do_request(input logic mode, input int addr, input int rdy_kind, input bit poke, input string tag);
    int   idx[$];
    int   k, guard, busy_n;
    logic rdy;
    if (mode) for (int i = 0; i < 16; i++) idx.push_back(i);
    else idx.push_back(addr);
    Mode = mode; Addr = addr[3:0]; Start = 1;
    tick();
    Start = 0;
    k = 0; guard = 0; busy_n = 0;
    while (k < idx.size() && guard < 200) begin
      check({tag, "_valid"}, OutValid, 1);
      check({tag, "_addr"}, OutAddr, idx[k]);
      check({tag, "_data"}, OutData, regs[idx[k]]);
      check({tag, "_busy"}, Busy, 1);
      check({tag, "_nodone"}, Done, 0);
`ifdef READ_PARITY_EN
      check({tag, "_par"}, OutParity, ^regs[idx[k]]);
`endif
      busy_n++;
      rdy = (rdy_kind == 0) ? 1'b1 : (rdy_kind == 1) ? guard[0] : 1'($urandom_range(0, 1));
      if (poke && guard == 3) begin Start = 1; Mode = 0; Addr = 4'd9; end
      else Start = 0;
      OutReady = rdy;
      tick();
      if (rdy) k++;
      guard++;
    end
    Start = 0; OutReady = 0;
    check({tag, "_count"}, k, idx.size());
    check({tag, "_done"}, Done, 1);
    check({tag, "_finvalid"}, OutValid, 0);
    check({tag, "_finbusy"}, Busy, 1);
    busy_n++;
    if (rdy_kind == 0) check({tag, "_busycyc"}, busy_n, idx.size() + 1);
    tick();
    check({tag, "_donepulse"}, Done, 0);
    check({tag, "_idle"}, Busy, 0);
  endtask

  initial begin
    bit [31:0] old;
    Reset = 0; Start = 0; Mode = 0; Addr = 0; OutReady = 0;
    preload();
    repeat (3) tick();
    check("rst_valid", OutValid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_data", OutData, 0);
    check("rst_addr", OutAddr, 0);
    Reset = 1;
    tick();

    do_request(0, 5, 0, 0, "single5");
    do_request(1, 0, 0, 0, "dump");
    do_request(1, 0, 1, 0, "bp");
    do_request(1, 0, 0, 1, "busy_start");

    // word sampled at load: changing the register while stalled must not alter it
    Mode = 0; Addr = 4'd7; Start = 1;
    tick();
    Start = 0; OutReady = 0;
    old = regs[7];
    regs[7] = $urandom | 32'h100;
    apply_regs();
    tick();
    check("hold_valid", OutValid, 1);
    check("hold_data", OutData, old);
    OutReady = 1;
    tick();
    OutReady = 0;
    check("hold_done", Done, 1);
    tick();
    preload();

    // reset after the fourth transfer of a dump
    Mode = 1; Addr = 0; Start = 1;
    tick();
    Start = 0; OutReady = 1;
    repeat (4) tick();
    check("mid_addr", OutAddr, 4);
    check("mid_data", OutData, 5);
    Reset = 0; OutReady = 0;
    tick();
    check("mid_valid", OutValid, 0);
    check("mid_busy", Busy, 0);
    check("mid_done", Done, 0);
    check("mid_data0", OutData, 0);
    Reset = 1;
    tick();
    check("mid_nodone", Done, 0);
    do_request(0, 2, 0, 0, "after_rst");

`ifdef READ_PARITY_EN
    regs[1] = 32'h7; regs[2] = 32'h3;
    apply_regs();
    Mode = 0; Addr = 4'd1; Start = 1;
    tick();
    Start = 0;
    check("par7", OutParity, 1);
    OutReady = 1;
    repeat (2) tick();
    Addr = 4'd2; Start = 1; OutReady = 0;
    tick();
    Start = 0;
    check("par3", OutParity, 0);
    OutReady = 1;
    repeat (2) tick();
    OutReady = 0;
    preload();
`endif

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      apply_regs();
      do_request(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 2, 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
